// File: rtl/pmu_sync_evt_arb.sv
// Round-robin arbiter sharing one fast-to-slow pulse-capture sync channel among NREQ requesters.
// Optional sticky overflow flags are enabled by defining PMU_SYNC_EVT_ARB_OVF_EN.
module pmu_sync_evt_arb #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int HOLD_TICKS = 2
) (
  input  logic             fast_clk,
  input  logic             cpu_rst,
  input  logic [NREQ-1:0]  req,
  input  logic             slow_tick,
  output logic             sync_in,
  output logic [IDW-1:0]   sync_id,
  output logic [NREQ-1:0]  ack,
  output logic             busy,
  output logic             done
`ifdef PMU_SYNC_EVT_ARB_OVF_EN
  ,
  output logic [NREQ-1:0]  ovf
`endif
);

  localparam int unsigned NR   = NREQ;
  localparam logic [3:0]  LAST = 4'(HOLD_TICKS - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, state_nx;
  logic [NREQ-1:0] pend, pend_nx, pend_clr;
  logic [IDW-1:0]  ptr, ptr_nx;
  logic [3:0]      cnt, cnt_nx;
  logic            sync_in_nx, busy_nx, done_nx;
  logic [NREQ-1:0] ack_nx;
  logic [IDW-1:0]  id_nx;

  logic            found;
  logic [IDW-1:0]  sel;
  logic [IDW:0]    cand;

  // Upward search from ptr; the extra bit on cand covers ptr+k before the wrap.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NR))
        cand = cand - (IDW+1)'(NR);
      if (!found && pend[cand[IDW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    sync_in_nx = 1'b0;
    ack_nx     = '0;
    id_nx      = sync_id;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    cnt_nx     = cnt;
    ptr_nx     = ptr;
    pend_clr   = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx   = HOLD;
          sync_in_nx = 1'b1;
          ack_nx     = NREQ'(1) << sel;
          id_nx      = sel;
          busy_nx    = 1'b1;
          cnt_nx     = '0;
          pend_clr   = NREQ'(1) << sel;
        end
      end
      HOLD: begin
        busy_nx = 1'b1;
        if (slow_tick) begin
          if (cnt == LAST) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            ptr_nx   = (sync_id == IDW'(NREQ - 1)) ? '0 : sync_id + 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // A new request in the grant cycle re-sets the bit being cleared.
    pend_nx = (pend & ~pend_clr) | req;
  end

  always_ff @(posedge fast_clk) begin
    if (cpu_rst) begin
      state   <= IDLE;
      pend    <= '0;
      ptr     <= '0;
      cnt     <= '0;
      sync_in <= 1'b0;
      ack     <= '0;
      sync_id <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      pend    <= pend_nx;
      ptr     <= ptr_nx;
      cnt     <= cnt_nx;
      sync_in <= sync_in_nx;
      ack     <= ack_nx;
      sync_id <= id_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

`ifdef PMU_SYNC_EVT_ARB_OVF_EN
  always_ff @(posedge fast_clk) begin
    if (cpu_rst)
      ovf <= '0;
    else
      ovf <= ovf | (req & pend & ~pend_clr);
  end
`endif

endmodule

// File: tb/tb_pmu_sync_evt_arb.sv
// Bench for pmu_sync_evt_arb: cycle vector table plus a grant-order scoreboard.
// Overflow checks are included when PMU_SYNC_EVT_ARB_OVF_EN is defined.
module tb_pmu_sync_evt_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       tick;
  logic       sync_in;
  logic [1:0] sync_id;
  logic [3:0] ack;
  logic       busy;
  logic       done;
`ifdef PMU_SYNC_EVT_ARB_OVF_EN
  logic [3:0] ovf;
`endif

  always #5 clk = ~clk;

  pmu_sync_evt_arb #(.NREQ(4), .IDW(2), .HOLD_TICKS(2)) dut (
    .fast_clk (clk),
    .cpu_rst  (rst),
    .req      (req),
    .slow_tick(tick),
    .sync_in  (sync_in),
    .sync_id  (sync_id),
    .ack      (ack),
    .busy     (busy),
    .done     (done)
`ifdef PMU_SYNC_EVT_ARB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       tick;
    logic       e_sync;
    logic [3:0] e_ack;
    logic [1:0] e_id;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tv[26];
  int   nvec = 0;
  int   nmis = 0;
  int   q[$];
  logic mon_en = 1'b0;

  // Grant monitor: every ack/sync_in pulse must match the next expected requester.
  int         e_idx;
  logic [3:0] e_ackm;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (ack != 4'b0 || sync_in) begin
        nvec++;
        if (q.size() == 0) begin
          nmis++;
          $display("FAIL extra_grant: ack=%b sync_id=%0d, required no grant", ack, sync_id);
        end else begin
          e_idx  = q.pop_front();
          e_ackm = 4'b0001 << e_idx;
          if ({sync_in, ack, sync_id, busy} !== {1'b1, e_ackm, 2'(e_idx), 1'b1}) begin
            nmis++;
            $display("FAIL grant: sync_in=%b ack=%b id=%0d busy=%b, required 1 %b %0d 1",
                     sync_in, ack, sync_id, busy, e_ackm, e_idx);
          end
        end
      end
      if (done) begin
        nvec++;
        if (busy !== 1'b0 || sync_in !== 1'b0) begin
          nmis++;
          $display("FAIL done_cycle: busy=%b sync_in=%b, required 0 0", busy, sync_in);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst    = 1'b1;
    req    = 4'h0;
    tick   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL timeout: %0d grants outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  initial begin
    //        rst  req   tk   sync ack   id  busy done
    tv[0]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0};
    tv[5]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1};
    tv[7]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd1, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd1, 1'b1, 1'b0};
    tv[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd1, 1'b0, 1'b1};
    tv[11] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2, 1'b1, 1'b0};
    tv[12] = '{1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd2, 1'b1, 1'b0};
    tv[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tv[14] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tv[15] = '{1'b0, 4'h4, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tv[16] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tv[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h4, 2'd2, 1'b1, 1'b0};
    tv[18] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd2, 1'b1, 1'b0};
    tv[19] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd2, 1'b1, 1'b0};
    tv[20] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd2, 1'b1, 1'b0};
    tv[21] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd2, 1'b1, 1'b0};
    tv[22] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd2, 1'b1, 1'b0};
    tv[23] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd2, 1'b0, 1'b1};
    tv[24] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd2, 1'b0, 1'b0};
    tv[25] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd2, 1'b0, 1'b0};

    rst  = 1'b1;
    req  = 4'hF;
    tick = 1'b0;
    step();

    // Outputs observed in each row are the result of the previous rows' inputs.
    for (int i = 0; i < 26; i++) begin
      rst  = tv[i].rst;
      req  = tv[i].req;
      tick = tv[i].tick;
      nvec++;
      if ({sync_in, ack, sync_id, busy, done} !==
          {tv[i].e_sync, tv[i].e_ack, tv[i].e_id, tv[i].e_busy, tv[i].e_done}) begin
        nmis++;
        $display("FAIL vec%0d: sync_in=%b ack=%b id=%0d busy=%b done=%b, required %b %b %0d %b %b",
                 i, sync_in, ack, sync_id, busy, done, tv[i].e_sync, tv[i].e_ack,
                 tv[i].e_id, tv[i].e_busy, tv[i].e_done);
      end
      step();
    end

    // Fairness: all requesters held high, every slow tick present.
    do_reset();
    tick = 1'b1;
    q.push_back(0); q.push_back(1); q.push_back(2); q.push_back(3); q.push_back(0);
    req = 4'hF;
    drain(100);

    // Set/clear collision on requester 1 with requester 3 also pending.
    do_reset();
    tick = 1'b1;
    q.push_back(1); q.push_back(3); q.push_back(1);
    req = 4'b1010;
    step();
    req = 4'b0010;
    step();
    req = 4'h0;
    drain(100);
    repeat (10) step();
`ifdef PMU_SYNC_EVT_ARB_OVF_EN
    chk4("ovf_collision", ovf, 4'b0000);
`endif

    // Coalescing: two req[3] pulses while requester 0 is held.
    do_reset();
    tick = 1'b0;
    q.push_back(0);
    req = 4'b0001;
    step();
    req = 4'h0;
    repeat (3) step();
    req = 4'b1000;
    step();
    req = 4'h0;
    step();
    req = 4'b1000;
    step();
    req = 4'h0;
    q.push_back(3);
    tick = 1'b1;
    drain(100);
    repeat (10) step();
`ifdef PMU_SYNC_EVT_ARB_OVF_EN
    chk4("ovf_sticky", ovf, 4'b1000);
`endif
    chk4("idle_after_coalesce", {busy, sync_in, done, 1'b0}, 4'b0000);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
